// File: rtl/ivar_sequencer.sv
// rtl/ivar_sequencer.sv - loop iteration-variable sequencer with valid/ready output
//
// Purpose: accepts a loop request (lb, ub, step), then produces the
// iteration values lb, lb+step, ... up to the largest value <= ub. Each
// value is offered on a valid/ready handshake. A one-cycle done pulse
// marks loop completion.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle loop request (honoured only in IDLE)
//   ivar_lb/ub/step     first value, inclusive signed bound, unsigned increment
//   ivar_ready          consumer accepts the current ivar
//   ivar/ivar_valid     current iteration value and its valid flag
//   ivar_last           current value is the final iteration
//   busy                loop in progress (RUN)
//   done                one-cycle completion pulse
module ivar_sequencer #(
  parameter int ITERATION_VARIABLE_WIDTH = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic signed [ITERATION_VARIABLE_WIDTH-1:0] ivar_lb,
  input  logic signed [ITERATION_VARIABLE_WIDTH-1:0] ivar_ub,
  input  logic        [ITERATION_VARIABLE_WIDTH-1:0] ivar_step,
  input  logic                                       ivar_ready,
  output logic signed [ITERATION_VARIABLE_WIDTH-1:0] ivar,
  output logic                                       ivar_valid,
  output logic                                       ivar_last,
  output logic                                       busy,
  output logic                                       done
);

  localparam int W  = ITERATION_VARIABLE_WIDTH;
  localparam int XW = W + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic signed [W-1:0]   ivar_q, ivar_d;
  logic signed [W-1:0]   ub_q, ub_d;
  logic        [W-1:0]   step_q, step_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Extended-width operands: lb/ub/ivar sign-extended, step zero-extended,
  // so value+step never wraps and the compare against ub stays exact.
  logic signed [XW-1:0]  lb_in_x, ub_in_x, step_in_x;
  logic signed [XW-1:0]  ub_q_x, step_q_x, nxt_x;
  logic signed [XW-1:0]  sum_start_x, sum_next_x;
  logic signed [W-1:0]   nxt_w;
  logic                  last_start, last_next;

  always_comb begin
    lb_in_x     = {{2{ivar_lb[W-1]}}, ivar_lb};
    ub_in_x     = {{2{ivar_ub[W-1]}}, ivar_ub};
    step_in_x   = {2'b00, ivar_step};
    ub_q_x      = {{2{ub_q[W-1]}}, ub_q};
    step_q_x    = {2'b00, step_q};

    // A zero step would repeat lb forever; it is a single-iteration loop.
    sum_start_x = lb_in_x + step_in_x;
    last_start  = (sum_start_x > ub_in_x) || (ivar_step == '0);

    // Only used when the current beat is not last, so ivar+step <= ub and
    // the W-bit sum cannot wrap. The following beat's last flag is
    // precomputed here so ivar_last can be a plain register.
    nxt_w       = W'(ivar_q + step_q);
    nxt_x       = {{2{nxt_w[W-1]}}, nxt_w};
    sum_next_x  = nxt_x + step_q_x;
    last_next   = sum_next_x > ub_q_x;
  end

  always_comb begin
    state_d = state_q;
    ivar_d  = ivar_q;
    ub_d    = ub_q;
    step_d  = step_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ub_d   = ivar_ub;
          step_d = ivar_step;
          ivar_d = ivar_lb;
          if (lb_in_x <= ub_in_x) begin
            state_d = S_RUN;
            valid_d = 1'b1;
            last_d  = last_start;
            busy_d  = 1'b1;
          end else begin
            // Empty loop: no beats, completion reported straight away.
            state_d = S_FIN;
            done_d  = 1'b1;
          end
        end
      end

      S_RUN: begin
        valid_d = 1'b1;
        last_d  = last_q;
        busy_d  = 1'b1;
        if (ivar_ready) begin
          if (last_q) begin
            state_d = S_FIN;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            ivar_d = nxt_w;
            last_d = last_next;
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ivar_q  <= '0;
      ub_q    <= '0;
      step_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ivar_q  <= ivar_d;
      ub_q    <= ub_d;
      step_q  <= step_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ivar       = ivar_q;
  assign ivar_valid = valid_q;
  assign ivar_last  = last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ivar_sequencer.sv
// tb/tb_ivar_sequencer.sv - self-checking bench for ivar_sequencer
module tb_ivar_sequencer;

  logic               clk;
  logic               rst;
  logic               start;
  logic signed [15:0] ivar_lb;
  logic signed [15:0] ivar_ub;
  logic        [15:0] ivar_step;
  logic               ivar_ready;
  logic signed [15:0] ivar;
  logic               ivar_valid;
  logic               ivar_last;
  logic               busy;
  logic               done;

  int checks;
  int failures;

  ivar_sequencer #(.ITERATION_VARIABLE_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ivar_lb    (ivar_lb),
    .ivar_ub    (ivar_ub),
    .ivar_step  (ivar_step),
    .ivar_ready (ivar_ready),
    .ivar       (ivar),
    .ivar_valid (ivar_valid),
    .ivar_last  (ivar_last),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int lb;
    int ub;
    int st;
    bit toggle;
    int exp_beats;
    int exp_final;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive_start(input int lb, input int ub, input int st);
    ivar_lb   = lb[15:0];
    ivar_ub   = ub[15:0];
    ivar_step = st[15:0];
    start     = 1'b1;
  endtask

  // Starts a loop, consumes every beat and checks values, last flag,
  // busy and the done pulse. Called at a negedge; returns at a negedge.
  task automatic run_loop(input vec_t v, input string name);
    int  k;
    int  cyc;
    int  last_seen;
    bit  rdy;
    drive_start(v.lb, v.ub, v.st);
    ivar_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    cyc = 0;
    rdy = 1'b1;
    last_seen = 0;
    if (v.exp_beats == 0) begin
      chk({name, "_empty_valid"}, int'(ivar_valid), 0);
      chk({name, "_empty_busy"}, int'(busy), 0);
      chk({name, "_empty_done"}, int'(done), 1);
    end else begin
      while (k < v.exp_beats && cyc < 200) begin
        chk({name, "_valid"}, int'(ivar_valid), 1);
        chk({name, "_ivar"}, int'(ivar), v.lb + k * v.st);
        chk({name, "_last"}, int'(ivar_last), (k == v.exp_beats - 1) ? 1 : 0);
        chk({name, "_busy"}, int'(busy), 1);
        chk({name, "_nodone"}, int'(done), 0);
        last_seen = int'(ivar);
        rdy = v.toggle ? ~rdy : 1'b1;
        ivar_ready = rdy;
        if (rdy) k++;
        @(negedge clk);
        cyc++;
      end
      chk({name, "_timeout"}, (cyc < 200) ? 1 : 0, 1);
      chk({name, "_final"}, last_seen, v.exp_final);
      chk({name, "_done"}, int'(done), 1);
      chk({name, "_valid_drop"}, int'(ivar_valid), 0);
      chk({name, "_busy_drop"}, int'(busy), 0);
    end
    ivar_ready = 1'b0;
    @(negedge clk);
    chk({name, "_done_once"}, int'(done), 0);
    chk({name, "_idle_valid"}, int'(ivar_valid), 0);
  endtask

  vec_t vecs[$];

  initial begin
    int n;
    checks = 0;
    failures = 0;

    vecs.push_back('{-2, 3, 2, 1'b0, 3, 2});
    vecs.push_back('{5, 4, 1, 1'b0, 0, 0});
    vecs.push_back('{32765, 32767, 1, 1'b1, 3, 32767});
    vecs.push_back('{7, 7, 0, 1'b0, 1, 7});
    vecs.push_back('{0, 10, 3, 1'b0, 4, 9});
    vecs.push_back('{-10, -3, 4, 1'b1, 2, -6});
    vecs.push_back('{-5, -6, 1, 1'b0, 0, 0});
    vecs.push_back('{32760, 32767, 65535, 1'b0, 1, 32760});
    vecs.push_back('{-32768, -32766, 1, 1'b0, 3, -32766});
    vecs.push_back('{4, 4, 9, 1'b1, 1, 4});

    rst = 1'b1;
    start = 1'b0;
    ivar_lb = '0;
    ivar_ub = '0;
    ivar_step = '0;
    ivar_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ivar", int'(ivar), 0);
    chk("reset_valid", int'(ivar_valid), 0);
    chk("reset_last", int'(ivar_last), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      run_loop(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset mid-loop aborts without done; reset beats start and handshake.
    drive_start(0, 10, 1);
    ivar_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 3) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_pre_ivar", int'(ivar), 3);
    rst = 1'b1;
    drive_start(1, 1, 1);
    @(negedge clk);
    chk("midrst_ivar", int'(ivar), 0);
    chk("midrst_valid", int'(ivar_valid), 0);
    chk("midrst_last", int'(ivar_last), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    rst = 1'b0;
    start = 1'b0;
    ivar_ready = 1'b0;
    @(negedge clk);
    chk("midrst_nodone", int'(done), 0);
    chk("midrst_idle", int'(ivar_valid), 0);
    run_loop('{1, 1, 1, 1'b0, 1, 1}, "after_rst");

    // Start during RUN and during FIN must be ignored.
    drive_start(0, 4, 2);
    ivar_ready = 1'b0;
    @(negedge clk);
    chk("restart_first", int'(ivar), 0);
    drive_start(100, 200, 7);
    @(negedge clk);
    start = 1'b0;
    chk("restart_hold", int'(ivar), 0);
    chk("restart_hold_valid", int'(ivar_valid), 1);
    ivar_ready = 1'b1;
    @(negedge clk);
    chk("restart_b1", int'(ivar), 2);
    chk("restart_b1_last", int'(ivar_last), 0);
    @(negedge clk);
    chk("restart_b2", int'(ivar), 4);
    chk("restart_b2_last", int'(ivar_last), 1);
    @(negedge clk);
    chk("restart_done", int'(done), 1);
    chk("restart_fin_ivar", int'(ivar), 4);
    ivar_ready = 1'b0;
    drive_start(50, 60, 1);
    @(negedge clk);
    start = 1'b0;
    chk("fin_start_valid", int'(ivar_valid), 0);
    chk("fin_start_done", int'(done), 0);
    @(negedge clk);
    chk("fin_start_idle", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
